serial_bin_tx: RTL and testbench
================================

# serial_bin_tx

MSB-first serial transmitter for binary words. It is the driving end of the serial line consumed by the divisible-by-5 detector. It accepts a parallel word through a valid/ready handshake and shifts it out one bit per clock. Alongside the bits it emits framing strobes and a reference "divisible by 5" flag, which the detector's result is checked against.

## Interface
- WIDTH, 8, word length in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- din  in  WIDTH  parallel word to send
- din_valid  in  1  din holds a word to send
- din_ready  out  1  block will accept din this cycle
- serial_op  out  1  current serial bit, MSB first
- bit_valid  out  1  serial_op carries a word bit this cycle
- first  out  1  serial_op is the MSB of a word
- last  out  1  serial_op is the LSB of a word
- div5  out  1  valid only with last: the word sent is ≡ 0 mod 5

## Operation
- States:
  - IDLE: no word loaded.
  - SHIFT: word in flight.
- Bit counter cnt runs from WIDTH-1 down to 0.
- Residue register res is 3 bits and always holds a value in 0..4.
- Transfer:
  - A word transfers on the rising edge where din_valid && din_ready.
  - din_ready = (state==IDLE) || (state==SHIFT && cnt==0).
  - The block accepts back-to-back words with no gap.
- On transfer:
  - Shift register sr ← din.
  - cnt ← WIDTH-1.
  - res ← 0.
  - state ← SHIFT.
- In SHIFT without a new transfer:
  - sr shifts left by 1.
  - res ← (2·res + serial_op) mod 5.
  - cnt decrements.
  - At cnt==0 with no transfer, state goes to IDLE.
- Outputs are Moore outputs, derived from registers only. There is no combinational path from din or din_valid to any output except din_ready, which also depends only on state and cnt.
  - serial_op = sr[WIDTH-1] in SHIFT; 0 in IDLE.
  - bit_valid = (state==SHIFT).
  - first = bit_valid && cnt==WIDTH-1.
  - last = bit_valid && cnt==0.
  - div5 = last && ((2·res + serial_op) mod 5 == 0); 0 whenever last=0.
- Residue arithmetic:
  - 2·res + bit ≤ 9 fits in 4 bits.
  - Reduce with a single conditional subtract of 5; a second subtract is never needed.
- din is sampled only at transfer. Changes to din while SHIFT and cnt≠0 are ignored.
- Held din_valid while busy: the word waits; nothing is dropped or duplicated.

## Timing
- Reset values (rst=0 at a clock edge):
  - state=IDLE, cnt=0, res=0, sr=0.
  - serial_op=0, bit_valid=0, first=0, last=0, div5=0, din_ready=1.
- Reset mid-word: the word in flight is abandoned. Outputs return to their reset values on the next cycle and the bit stream is not resumed.
- Latency: MSB appears on serial_op in the cycle after the transfer edge. The LSB appears WIDTH-1 cycles later, together with last and div5.
- Throughput: one word every WIDTH cycles with back-to-back transfers. bit_valid stays high continuously and first follows last in the next cycle.
- Transfer and reset on the same edge: reset wins and the word is not accepted.
- Receiver framing: the detector does not clear its residue between words. The bench must reset the detector, or compare against div5 per word, using first to delimit words.

## Structure
- Package serial_bin_pkg holds:
  - state enum {IDLE, SHIFT}
  - RES_W = 3 constant
  - function mod5_step(res, bit), which returns (2·res+bit) mod 5
- The detector bench model reuses this package.
- Sub-module serial_mod5_step is a natural split: a combinational residue-update slice, instantiated once here, with the same function shared by the checker.
- Top level contains the state register, counter, shift register and residue register.

## Test plan
- WIDTH=8, din=8'd25 accepted: bits 0,0,0,1,1,0,0,1 on cycles 1–8 after transfer; first on cycle 1; last and div5=1 on cycle 8.
- din=8'd26: same framing; div5=0 with last. din=8'd0: div5=1.
- Back-to-back 8'hFF then 8'h07, din_valid held high: din_ready high on the LSB cycle of 0xFF; bit_valid continuous for 16 cycles.
  - 0xFF (255): div5=1.
  - 0x07 (7): div5=0.
  - first on cycle 9.
- din_valid high and din changing during SHIFT with cnt≠0: no transfer, and the serial stream matches the originally latched word.
- rst=0 asserted on the 4th bit of a word: next cycle all outputs are 0 and din_ready=1. A new word sent afterwards is serialized correctly with res restarted.
- Closed loop against the detector (reset between words), all 256 values with WIDTH=8: detector z after the last bit equals div5 for every word.

Source files
------------

// File: rtl/serial_bin_pkg.sv
// Shared definitions for the serial binary transmitter and its mod-5 checkers.
// Contents: transmitter state enum, residue width, and the mod-5 residue step.
package serial_bin_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int unsigned RES_W = 3;

  // Returns (2*res + data_bit) mod 5 for res in 0..4. The sum is at most 9,
  // so a single conditional subtract of 5 fully reduces it.
  function automatic logic [RES_W-1:0] mod5_step(input logic [RES_W-1:0] res,
                                                 input logic             data_bit);
    logic [RES_W:0] sum;
    sum = {res, data_bit};
    if (sum >= (RES_W+1)'(5)) begin
      sum = sum - (RES_W+1)'(5);
    end
    return RES_W'(sum);
  endfunction

endpackage

// File: rtl/serial_mod5_step.sv
// Combinational residue-update slice: next_res_c = (2*res + data_bit) mod 5.
// Ports:
//   res        - current residue, 0..4
//   data_bit   - incoming serial bit
//   next_res_c - updated residue, 0..4
module serial_mod5_step
  import serial_bin_pkg::*;
(
  input  logic [RES_W-1:0] res,
  input  logic             data_bit,
  output logic [RES_W-1:0] next_res_c
);

  assign next_res_c = mod5_step(res, data_bit);

endmodule

// File: rtl/serial_bin_tx.sv
// MSB-first serial transmitter with framing strobes and a divisible-by-5 flag.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous reset, active low
//   din        - parallel word, sampled only on a transfer edge
//   din_valid  - din holds a word to send
//   din_ready  - word accepted this cycle (idle, or on the LSB of the current word)
//   serial_op  - current serial bit, MSB first
//   bit_valid  - serial_op carries a word bit
//   first      - serial_op is the MSB of a word
//   last       - serial_op is the LSB of a word
//   div5       - with last: the word just sent is a multiple of 5
module serial_bin_tx
  import serial_bin_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             serial_op,
  output logic             bit_valid,
  output logic             first,
  output logic             last,
  output logic             div5
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [RES_W-1:0] res_q, res_d;
  logic [RES_W-1:0] step_res;
  logic             xfer;

  // Residue including the bit currently on the line.
  serial_mod5_step u_step (
    .res        (res_q),
    .data_bit   (serial_op),
    .next_res_c (step_res)
  );

  // Moore outputs, decoded from registers only.
  assign din_ready = (state_q == IDLE) || (cnt_q == '0);
  assign xfer      = din_valid && din_ready;
  assign bit_valid = (state_q == SHIFT);
  assign serial_op = bit_valid && sr_q[WIDTH-1];
  assign first     = bit_valid && (cnt_q == CNT_TOP);
  assign last      = bit_valid && (cnt_q == '0);
  assign div5      = last && (step_res == '0);

  // State, counter, shift and residue registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      res_q   <= res_d;
    end
  end

  // Next-state: a transfer (including back-to-back on the LSB) reloads
  // everything; otherwise shift one bit and fold it into the residue.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    res_d   = res_q;
    if (xfer) begin
      state_d = SHIFT;
      cnt_d   = CNT_TOP;
      sr_d    = din;
      res_d   = '0;
    end else if (state_q == SHIFT) begin
      sr_d  = {sr_q[WIDTH-2:0], 1'b0};
      res_d = step_res;
      if (cnt_q == '0) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_bin_tx.sv
// Self-checking bench for serial_bin_tx (WIDTH=8): framing, div5 flag,
// back-to-back transfers, ignored din changes, mid-word reset, all 256 words.
module tb_serial_bin_tx;

  localparam int unsigned WIDTH = 8;
  localparam logic [5:0] IDLE_V = 6'b100000;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready, serial_op, bit_valid, first, last, div5;
  logic [5:0]       obs;
  int               total = 0;
  int               bad = 0;

  always #5 clk = ~clk;

  serial_bin_tx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .serial_op (serial_op),
    .bit_valid (bit_valid),
    .first     (first),
    .last      (last),
    .div5      (div5)
  );

  assign obs = {din_ready, serial_op, bit_valid, first, last, div5};

  // Expected {din_ready, serial_op, bit_valid, first, last, div5} on the
  // i-th bit cycle (0 = MSB) of word w.
  function automatic logic [5:0] model(input logic [7:0] w, input int i);
    logic [7:0] t;
    logic       b;
    logic       z;
    t = w >> (7 - i);
    b = t[0];
    z = ((int'(w) % 5) == 0);
    return {i == 7, b, 1'b1, i == 0, i == 7, (i == 7) && z};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; din_valid = 1'b0; din = '0;
    tick(); tick();
    total++;
    if (obs !== IDLE_V) begin
      bad++; $display("FAIL reset_state: got %b want %b", obs, IDLE_V);
    end
    rst = 1'b1;
    tick();
    total++;
    if (obs !== IDLE_V) begin
      bad++; $display("FAIL reset_release: got %b want %b", obs, IDLE_V);
    end
  endtask

  // One isolated word; din is scrambled after the transfer to show it is ignored.
  task automatic test_word(input logic [7:0] w);
    din = w; din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (obs !== model(w, i)) begin
        bad++; $display("FAIL word_%0d bit%0d: got %b want %b", w, i, obs, model(w, i));
      end
      if (i == 0) begin
        din_valid = 1'b0; din = 8'($urandom);
      end
    end
    tick();
    total++;
    if (obs !== IDLE_V) begin
      bad++; $display("FAIL word_%0d idle_after: got %b want %b", w, obs, IDLE_V);
    end
  endtask

  // din_valid held high throughout; din changes randomly while busy and the
  // next word is presented only on the LSB cycle.
  task automatic test_back_to_back();
    logic [7:0] words[$];
    words.push_back(8'hFF);
    words.push_back(8'h07);
    for (int k = 0; k < 4; k++) words.push_back(8'($urandom));
    din = words[0]; din_valid = 1'b1;
    for (int k = 0; k < words.size(); k++) begin
      for (int i = 0; i < 8; i++) begin
        tick();
        total++;
        if (obs !== model(words[k], i)) begin
          bad++;
          $display("FAIL b2b w%0d=%0d bit%0d: got %b want %b", k, words[k], i, obs,
                   model(words[k], i));
        end
        if (i < 7) din = 8'($urandom);
        else if (k + 1 < words.size()) din = words[k+1];
        else din_valid = 1'b0;
      end
    end
    tick();
    total++;
    if (obs !== IDLE_V) begin
      bad++; $display("FAIL b2b idle_after: got %b want %b", obs, IDLE_V);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    w = 8'($urandom);
    din = w; din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (obs !== model(w, i)) begin
        bad++; $display("FAIL midrst_pre bit%0d: got %b want %b", i, obs, model(w, i));
      end
      if (i == 0) din_valid = 1'b0;
    end
    // Reset on the 4th bit, with a transfer request on the same edge.
    rst = 1'b0; din_valid = 1'b1; din = 8'($urandom);
    tick();
    total++;
    if (obs !== IDLE_V) begin
      bad++; $display("FAIL midrst_abandon: got %b want %b", obs, IDLE_V);
    end
    rst = 1'b1; din_valid = 1'b0;
    tick();
    total++;
    if (obs !== IDLE_V) begin
      bad++; $display("FAIL midrst_no_accept: got %b want %b", obs, IDLE_V);
    end
    test_word(8'($urandom));
  endtask

  // Every word value, random order offset and gaps; a bench-side receiver
  // rebuilds each word from the line and judges divisibility itself.
  task automatic test_all_values();
    int unsigned base;
    int          acc;
    bit          seen;
    base = $urandom_range(0, 255);
    for (int n = 0; n < 256; n++) begin
      logic [7:0] w;
      w = 8'(base + n);
      repeat ($urandom_range(0, 2)) tick();
      din = w; din_valid = 1'b1;
      acc = 0; seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
        tick();
        if (c == 0) din_valid = 1'b0;
        if (bit_valid) begin
          if (first) acc = 0;
          acc = acc * 2 + int'(serial_op);
          if (last) begin
            seen = 1'b1;
            total++;
            if (acc != int'(w) || div5 !== ((acc % 5) == 0)) begin
              bad++;
              $display("FAIL loop_%0d: got word=%0d div5=%b want word=%0d div5=%b",
                       w, acc, div5, w, ((int'(w) % 5) == 0));
            end
          end
        end
      end
      if (!seen) begin
        total++; bad++;
        $display("FAIL loop_%0d timeout: got no last want last within 12 cycles", w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word(8'd25);
    test_word(8'd26);
    test_word(8'd0);
    test_back_to_back();
    test_reset_mid();
    test_all_values();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
